// File: rtl/mem_access_unit.sv
// Load/store sequencer: accepts one memory op, issues a single-cycle request,
// captures the registered response, extends load data and holds the result for writeback.
// Optional feature macro: MEM_ACCESS_ALIGN_CHECK_EN (trap misaligned ops at accept, no memory request).
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int MEM_COUNT_W = 2,
  parameter int MEM_CODE_W  = 3,
  parameter int REG_IDX_W   = 5
) (
  input  logic                   clk,
  input  logic                   areset,
  // execute side
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [WORD_W-1:0]      i_wr_data,
  input  logic                   i_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_count,
  input  logic                   i_unsigned,
  input  logic [REG_IDX_W-1:0]   i_rd_idx,
  // memory side
  output logic [ADDR_W-1:0]      o_req_addr,
  output logic [WORD_W-1:0]      o_req_wr_data,
  output logic                   o_req_wr_en,
  output logic [MEM_COUNT_W-1:0] o_req_count,
  input  logic [WORD_W-1:0]      i_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_res_code,
  // writeback side
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WORD_W-1:0]      o_rd_data,
  output logic [REG_IDX_W-1:0]   o_rd_idx,
  output logic                   o_rd_we,
  output logic                   o_exc,
  output logic [MEM_CODE_W-1:0]  o_exc_code
);

  // Shared encodings with memory_interface.
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = MEM_COUNT_W'(0);
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = MEM_COUNT_W'(1);
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = MEM_COUNT_W'(2);
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = MEM_COUNT_W'(3);

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ       = MEM_CODE_W'(1);
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE      = MEM_CODE_W'(2);
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED = MEM_CODE_W'(3);
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID    = MEM_CODE_W'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Latched operation
  logic [ADDR_W-1:0]      op_addr;
  logic [WORD_W-1:0]      op_wr_data;
  logic                   op_wr_en;
  logic [MEM_COUNT_W-1:0] op_count;
  logic                   op_unsigned;
  logic [REG_IDX_W-1:0]   op_rd_idx;

  // Registered result
  logic [WORD_W-1:0]      res_data;
  logic                   res_we;
  logic                   res_exc;
  logic [MEM_CODE_W-1:0]  res_code;

  // Formatted response (valid in RESP)
  logic [WORD_W-1:0]      ext_data;
  logic [WORD_W-1:0]      fmt_data;
  logic                   fmt_we;
  logic                   fmt_exc;
  logic [MEM_CODE_W-1:0]  fmt_code;

  logic accept;
  logic misaligned;

  assign accept = i_valid && (state == S_IDLE);

  always_comb begin
    misaligned = 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (i_count == MEM_COUNT_HALF)      misaligned = i_addr[0];
    else if (i_count == MEM_COUNT_WORD) misaligned = |i_addr[1:0];
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_valid) state_nxt = misaligned ? S_DONE : S_REQ;
      S_REQ:   state_nxt = S_RESP;
      S_RESP:  state_nxt = S_DONE;
      S_DONE:  if (i_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sign/zero extension of the right-justified memory read data.
  always_comb begin
    ext_data = i_res_rd_data;
    case (op_count)
      MEM_COUNT_BYTE:
        ext_data = {{(WORD_W-8){~op_unsigned & i_res_rd_data[7]}}, i_res_rd_data[7:0]};
      MEM_COUNT_HALF:
        ext_data = {{(WORD_W-16){~op_unsigned & i_res_rd_data[15]}}, i_res_rd_data[15:0]};
      default: ext_data = i_res_rd_data;
    endcase
  end

  // Response codes outside the known set collapse to INVALID.
  always_comb begin
    fmt_data = '0;
    fmt_we   = 1'b0;
    fmt_exc  = 1'b0;
    fmt_code = '0;
    case (i_res_code)
      MEM_CODE_READ: begin
        fmt_data = ext_data;
        fmt_we   = (op_rd_idx != '0);
      end
      MEM_CODE_WRITE: ;
      MEM_CODE_MISALIGNED: begin
        fmt_exc  = 1'b1;
        fmt_code = MEM_CODE_MISALIGNED;
      end
      default: begin
        fmt_exc  = 1'b1;
        fmt_code = MEM_CODE_INVALID;
      end
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      op_addr     <= '0;
      op_wr_data  <= '0;
      op_wr_en    <= 1'b0;
      op_count    <= MEM_COUNT_NONE;
      op_unsigned <= 1'b0;
      op_rd_idx   <= '0;
      res_data    <= '0;
      res_we      <= 1'b0;
      res_exc     <= 1'b0;
      res_code    <= '0;
    end else begin
      if (accept) begin
        op_addr     <= i_addr;
        op_wr_data  <= i_wr_data;
        op_wr_en    <= i_wr_en;
        op_count    <= i_count;
        op_unsigned <= i_unsigned;
        op_rd_idx   <= i_rd_idx;
        if (misaligned) begin
          res_data <= '0;
          res_we   <= 1'b0;
          res_exc  <= 1'b1;
          res_code <= MEM_CODE_MISALIGNED;
        end
      end
      if (state == S_RESP) begin
        res_data <= fmt_data;
        res_we   <= fmt_we;
        res_exc  <= fmt_exc;
        res_code <= fmt_code;
      end
    end
  end

  // Memory request is live only during REQ.
  always_comb begin
    o_req_addr    = '0;
    o_req_wr_data = '0;
    o_req_wr_en   = 1'b0;
    o_req_count   = MEM_COUNT_NONE;
    if (state == S_REQ) begin
      o_req_addr    = op_addr;
      o_req_wr_data = op_wr_data;
      o_req_wr_en   = op_wr_en;
      o_req_count   = op_count;
    end
  end

  assign o_ready    = (state == S_IDLE);
  assign o_valid    = (state == S_DONE);
  assign o_rd_data  = res_data;
  assign o_rd_idx   = op_rd_idx;
  assign o_rd_we    = res_we;
  assign o_exc      = res_exc;
  assign o_exc_code = res_code;

endmodule
